// File: rtl/sys_mem_part_ctrl.sv
// Memory partition controller: per-agent start/end/pointer registers, wrap-around
// address grants with one cycle of latency, programmed over the local bus.
module sys_mem_part_ctrl #(
  parameter int MEM_ADDR_W = 27,
  parameter int NUM_AGENTS = 4,
  parameter int LB_DATA_W = 32,
  parameter int LB_ADDR_W = 8,
  parameter int LEN_W = 8,
  parameter logic [LB_DATA_W-1:0] DEFAULT_DATA_VAL = 'hdeadbabe,
  parameter int AGENT_ID_W = $clog2(NUM_AGENTS),
  parameter int PART_SIZE = (2**MEM_ADDR_W) / NUM_AGENTS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lb_wr_en,
  input  logic                  lb_rd_en,
  input  logic [LB_ADDR_W-1:0]  lb_addr,
  input  logic [LB_DATA_W-1:0]  lb_wr_data,
  output logic                  lb_wr_valid,
  output logic                  lb_rd_valid,
  output logic [LB_DATA_W-1:0]  lb_rd_data,
  input  logic                  agent_req,
  input  logic [AGENT_ID_W-1:0] agent_id,
  input  logic [LEN_W-1:0]      agent_len,
  output logic                  agent_gnt,
  output logic [MEM_ADDR_W-1:0] agent_addr,
  output logic                  agent_err,
  output logic                  busy
);
  // LB handshake: a strobe held for one cycle is always accepted; the matching
  // lb_wr_valid / lb_rd_valid pulse follows exactly one cycle later, no back-pressure.
  localparam int AW1 = MEM_ADDR_W + 1;
  localparam logic [LB_ADDR_W-1:0] REG_CNTRL  = LB_ADDR_W'(0);
  localparam logic [LB_ADDR_W-1:0] REG_STATUS = LB_ADDR_W'(1);
  localparam logic [LB_ADDR_W-1:0] REG_NUM    = LB_ADDR_W'(2);
  localparam logic [LB_ADDR_W-1:0] REG_ADDR   = LB_ADDR_W'(3);
  localparam logic [LB_ADDR_W-1:0] REG_START  = LB_ADDR_W'(4);
  localparam logic [LB_ADDR_W-1:0] REG_END    = LB_ADDR_W'(5);
  localparam logic [LB_ADDR_W-1:0] REG_PTR    = LB_ADDR_W'(6);

  typedef enum logic {S_IDLE, S_INIT} state_t;

  state_t                  state;
  logic [AGENT_ID_W-1:0]   init_cnt;
  logic                    mode;
  logic [AGENT_ID_W-1:0]   hst_addr;
  logic                    cfg_err;
  logic                    len_err;
  logic [MEM_ADDR_W-1:0]   start_r [NUM_AGENTS];
  logic [MEM_ADDR_W-1:0]   end_r   [NUM_AGENTS];
  logic [MEM_ADDR_W-1:0]   ptr_r   [NUM_AGENTS];

  logic                    in_init;
  logic                    cfg_ok;
  logic [AGENT_ID_W-1:0]   wr_id;
  logic [MEM_ADDR_W-1:0]   wr_addr;
  logic [AW1-1:0]          init_start, init_end;
  logic [AW1-1:0]          g_start, g_end, g_ptr, g_len, g_span, g_last, g_base, g_next;
  logic                    id_bad, len_bad, req_bad;
  logic [LB_DATA_W-1:0]    rd_next;
  logic                    unused_bits;

  assign in_init    = (state == S_INIT);
  assign cfg_ok     = mode && !in_init;
  assign wr_id      = lb_wr_data[AGENT_ID_W-1:0];
  assign wr_addr    = lb_wr_data[MEM_ADDR_W-1:0];
  assign init_start = AW1'(init_cnt) * AW1'(PART_SIZE);
  assign init_end   = init_start + AW1'(PART_SIZE - 1);
  assign unused_bits = ^{lb_wr_data, init_end[AW1-1], init_start[AW1-1]};

  // Grant evaluation is one bit wider than the address so p+L never wraps.
  always_comb begin
    g_start = {1'b0, start_r[agent_id]};
    g_end   = {1'b0, end_r[agent_id]};
    g_ptr   = {1'b0, ptr_r[agent_id]};
    g_len   = AW1'(agent_len);
    g_span  = g_end - g_start + AW1'(1);
    g_last  = g_ptr + g_len - AW1'(1);
    g_base  = (g_last <= g_end) ? g_ptr : g_start;
    g_next  = g_base + g_len;
    if (g_next > g_end) g_next = g_start;
    id_bad  = (AGENT_ID_W+1)'(agent_id) >= (AGENT_ID_W+1)'(NUM_AGENTS);
    len_bad = (agent_len == '0) || (g_len > g_span);
    req_bad = mode || in_init || id_bad || len_bad;
  end

  always_comb begin
    rd_next = DEFAULT_DATA_VAL;
    case (lb_addr)
      REG_CNTRL:  rd_next = LB_DATA_W'(mode);
      REG_STATUS: rd_next = LB_DATA_W'({len_err, cfg_err, busy});
      REG_NUM:    rd_next = LB_DATA_W'(NUM_AGENTS);
      REG_ADDR:   rd_next = LB_DATA_W'(hst_addr);
      REG_START:  rd_next = LB_DATA_W'(start_r[hst_addr]);
      REG_END:    rd_next = LB_DATA_W'(end_r[hst_addr]);
      REG_PTR:    rd_next = LB_DATA_W'(ptr_r[hst_addr]);
      default:    rd_next = DEFAULT_DATA_VAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_INIT;
      init_cnt    <= '0;
      busy        <= 1'b0;
      mode        <= 1'b0;
      hst_addr    <= '0;
      cfg_err     <= 1'b0;
      len_err     <= 1'b0;
      lb_wr_valid <= 1'b0;
      lb_rd_valid <= 1'b0;
      lb_rd_data  <= '0;
      agent_gnt   <= 1'b0;
      agent_err   <= 1'b0;
      agent_addr  <= '0;
    end else begin
      lb_wr_valid <= lb_wr_en;
      lb_rd_valid <= lb_rd_en;
      agent_gnt   <= 1'b0;
      agent_err   <= 1'b0;
      if (lb_rd_en) lb_rd_data <= rd_next;

      // Coming out of reset, the first INIT cycle only raises busy; the sweep follows.
      case (state)
        S_INIT: begin
          if (!busy) begin
            busy <= 1'b1;
          end else begin
            start_r[init_cnt] <= init_start[MEM_ADDR_W-1:0];
            end_r[init_cnt]   <= init_end[MEM_ADDR_W-1:0];
            ptr_r[init_cnt]   <= init_start[MEM_ADDR_W-1:0];
            if (init_cnt == AGENT_ID_W'(NUM_AGENTS - 1)) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              init_cnt <= init_cnt + AGENT_ID_W'(1);
            end
          end
        end
        default: ;
      endcase

      if (lb_wr_en) begin
        case (lb_addr)
          REG_CNTRL: begin
            mode <= lb_wr_data[0];
            if (lb_wr_data[1]) begin
              state    <= S_INIT;
              init_cnt <= '0;
              busy     <= 1'b1;
            end
          end
          REG_STATUS: begin
            if (lb_wr_data[1]) cfg_err <= 1'b0;
            if (lb_wr_data[2]) len_err <= 1'b0;
          end
          REG_ADDR: begin
            if ((AGENT_ID_W+1)'(wr_id) >= (AGENT_ID_W+1)'(NUM_AGENTS)) cfg_err <= 1'b1;
            else hst_addr <= wr_id;
          end
          REG_START: begin
            if (cfg_ok) begin
              start_r[hst_addr] <= wr_addr;
              ptr_r[hst_addr]   <= wr_addr;
            end else begin
              cfg_err <= 1'b1;
            end
          end
          REG_END: begin
            if (cfg_ok && (wr_addr >= start_r[hst_addr])) end_r[hst_addr] <= wr_addr;
            else cfg_err <= 1'b1;
          end
          default: ;
        endcase
      end

      // Judged on pre-write mode and current pointers; the ptr update lands for the next request.
      if (agent_req) begin
        if (req_bad) begin
          agent_err <= 1'b1;
          if (len_bad && !id_bad) len_err <= 1'b1;
        end else begin
          agent_gnt       <= 1'b1;
          agent_addr      <= g_base[MEM_ADDR_W-1:0];
          ptr_r[agent_id] <= g_next[MEM_ADDR_W-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_sys_mem_part_ctrl.sv
// Bench for sys_mem_part_ctrl: directed vector tables plus hand sequences, with
// read-data and grant scoreboards fed at drive time and drained by a monitor.
module tb_sys_mem_part_ctrl;
  localparam int MW = 27;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NA = 4;
  localparam longint PS = 64'h2000000;
  localparam logic [AW-1:0] R_CNTRL = 8'h00, R_STATUS = 8'h01, R_NUM = 8'h02,
    R_ADDR = 8'h03, R_START = 8'h04, R_END = 8'h05, R_PTR = 8'h06;

  logic clk = 1'b0, rst = 1'b1;
  logic lb_wr_en = 1'b0, lb_rd_en = 1'b0;
  logic [AW-1:0] lb_addr = '0;
  logic [DW-1:0] lb_wr_data = '0;
  logic lb_wr_valid, lb_rd_valid;
  logic [DW-1:0] lb_rd_data;
  logic agent_req = 1'b0;
  logic [1:0] agent_id = '0;
  logic [7:0] agent_len = '0;
  logic agent_gnt, agent_err, busy;
  logic [MW-1:0] agent_addr;

  sys_mem_part_ctrl dut (
    .clk(clk), .rst(rst), .lb_wr_en(lb_wr_en), .lb_rd_en(lb_rd_en), .lb_addr(lb_addr),
    .lb_wr_data(lb_wr_data), .lb_wr_valid(lb_wr_valid), .lb_rd_valid(lb_rd_valid),
    .lb_rd_data(lb_rd_data), .agent_req(agent_req), .agent_id(agent_id),
    .agent_len(agent_len), .agent_gnt(agent_gnt), .agent_addr(agent_addr),
    .agent_err(agent_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic err; logic [MW-1:0] addr; } gexp_t;
  typedef struct { int id; int len; bit err; longint addr; } vec_t;

  logic [DW-1:0] exp_q[$];
  gexp_t gnt_q[$];
  int vec_cnt = 0, mis_cnt = 0;
  logic [MW-1:0] last_addr = '0;
  longint m_start[NA], m_end[NA], m_ptr[NA];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic lb_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    lb_wr_en = 1'b1; lb_addr = a; lb_wr_data = d;
    @(posedge clk); #1;
    check("wr_valid", lb_wr_valid, 1);
    lb_wr_en = 1'b0;
  endtask

  task automatic lb_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
    exp_q.push_back(e);
    lb_rd_en = 1'b1; lb_addr = a;
    @(posedge clk); #1;
    lb_rd_en = 1'b0;
  endtask

  task automatic expect_gnt(input bit err, input longint addr);
    gexp_t g;
    g.err = err; g.addr = MW'(addr);
    gnt_q.push_back(g);
  endtask

  task automatic agent_request(input int id, input int len, input bit err, input longint addr);
    expect_gnt(err, addr);
    agent_req = 1'b1; agent_id = 2'(id); agent_len = 8'(len);
    @(posedge clk); #1;
    agent_req = 1'b0;
  endtask

  task automatic run_table(input vec_t t[]);
    foreach (t[i]) agent_request(t[i].id, t[i].len, t[i].err, t[i].addr);
  endtask

  // Monitor: scoreboards are drained on the falling edge, away from the update edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (lb_rd_valid) begin
        if (exp_q.size() == 0) begin
          vec_cnt++; mis_cnt++;
          $display("FAIL rd_unexpected: got data 0x%0h with no read outstanding", lb_rd_data);
        end else begin
          check("rd_data", lb_rd_data, exp_q.pop_front());
        end
      end
      if (agent_gnt || agent_err) begin
        if (gnt_q.size() == 0) begin
          vec_cnt++; mis_cnt++;
          $display("FAIL gnt_unexpected: got gnt=%0b err=%0b with no request outstanding",
                   agent_gnt, agent_err);
        end else begin
          gexp_t g;
          g = gnt_q.pop_front();
          if (g.err) check("agent_err", {agent_gnt, agent_err, agent_addr}, {2'b01, last_addr});
          else begin
            check("agent_gnt", {agent_gnt, agent_err, agent_addr}, {2'b10, g.addr});
            last_addr = g.addr;
          end
        end
      end
    end
  end

  initial begin
    vec_t norm_tab[] = '{
      '{1, 16, 1'b0, 64'h2000000}, '{1, 16, 1'b0, 64'h2000010}, '{1, 16, 1'b0, 64'h2000020},
      '{3, 1, 1'b0, 64'h6000000},  '{0, 255, 1'b0, 64'h0},      '{0, 1, 1'b0, 64'hFF},
      '{2, 128, 1'b0, 64'h4000000}};
    vec_t cfg_tab[] = '{
      '{0, 16, 1'b0, 64'h100}, '{0, 16, 1'b0, 64'h110}, '{0, 16, 1'b0, 64'h100}};
    vec_t len_tab[] = '{
      '{0, 0, 1'b1, 64'h0}, '{0, 33, 1'b1, 64'h0}, '{0, 32, 1'b0, 64'h100}};

    for (int i = 0; i < NA; i++) begin
      m_start[i] = i * PS; m_end[i] = i * PS + PS - 1; m_ptr[i] = i * PS;
    end
    m_ptr[2] = 64'h4000080;
    m_ptr[3] = 64'h6000001;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_gnt_err", {agent_gnt, agent_err}, 0);
    check("rst_addr", agent_addr, 0);
    check("rst_valids", {lb_wr_valid, lb_rd_valid}, 0);
    check("rst_rd_data", lb_rd_data, 0);
    rst = 1'b0;

    // Init sweep after reset: busy for exactly NUM_AGENTS cycles
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("boot_busy_%0d", k), busy, (k <= 4) ? 1 : 0);
    end

    lb_write(R_ADDR, 2);
    lb_read(R_START, 32'h4000000);
    lb_read(R_END, 32'h5FFFFFF);
    lb_read(R_ADDR, 2);
    lb_read(R_NUM, NA);
    lb_read(R_CNTRL, 0);
    lb_read(R_STATUS, 0);

    // Normal mode grants from default partitions
    run_table(norm_tab);

    // Random traffic on agents 2 and 3 against a reference pointer model
    for (int i = 0; i < 24; i++) begin
      int id, len;
      longint base, nxt;
      id = $urandom_range(2, 3);
      len = $urandom_range(1, 255);
      base = (m_ptr[id] + len - 1 <= m_end[id]) ? m_ptr[id] : m_start[id];
      nxt = base + len;
      m_ptr[id] = (nxt > m_end[id]) ? m_start[id] : nxt;
      agent_request(id, len, 1'b0, base);
    end

    // Reprogram agent 0 to a small partition and exercise wrap
    lb_write(R_CNTRL, 1);
    lb_write(R_ADDR, 0);
    lb_write(R_START, 32'h100);
    lb_write(R_END, 32'h11F);
    lb_read(R_STATUS, 0);
    lb_write(R_CNTRL, 0);
    run_table(cfg_tab);
    lb_read(R_PTR, 32'h110);

    // Mode write and request in one cycle: request sees the old mode
    expect_gnt(1'b0, 64'h110);
    lb_wr_en = 1'b1; lb_addr = R_CNTRL; lb_wr_data = 1;
    agent_req = 1'b1; agent_id = 0; agent_len = 16;
    @(posedge clk); #1;
    check("wr_valid_mixed", lb_wr_valid, 1);
    lb_wr_en = 1'b0; agent_req = 1'b0;
    agent_request(0, 16, 1'b1, 0);
    lb_read(R_STATUS, 0);
    lb_read(R_PTR, 32'h100);

    // Config errors: END below START, START in normal mode
    lb_write(R_END, 32'hFF);
    lb_read(R_END, 32'h11F);
    lb_read(R_STATUS, 2);
    lb_write(R_STATUS, 2);
    lb_read(R_STATUS, 0);
    lb_write(R_CNTRL, 0);
    lb_write(R_START, 32'h200);
    lb_read(R_START, 32'h100);
    lb_read(R_STATUS, 2);
    lb_write(R_STATUS, 2);

    // Length errors, then exact-fit length
    run_table(len_tab);
    lb_read(R_STATUS, 4);
    lb_write(R_STATUS, 4);
    lb_read(R_STATUS, 0);

    // Init command mid-traffic
    agent_request(1, 16, 1'b0, 64'h2000030);
    lb_write(R_CNTRL, 2);
    check("init_busy", busy, 1);
    for (int k = 0; k < 4; k++) agent_request(1, 16, 1'b1, 0);
    check("init_done_busy", busy, 0);
    agent_request(1, 16, 1'b0, 64'h2000000);
    agent_request(0, 16, 1'b0, 64'h0);
    lb_read(R_START, 0);
    lb_read(R_END, 32'h1FFFFFF);
    lb_read(R_PTR, 32'h10);
    lb_read(8'h20, 32'hdeadbabe);

    repeat (5) @(posedge clk);
    #1;
    check("rd_q_drained", exp_q.size(), 0);
    check("gnt_q_drained", gnt_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end
endmodule

// File: doc/sys_mem_part_ctrl.md
Name: sys_mem_part_ctrl

Overview:
Partition controller for the system memory interface. It holds a start/end address pair and a running allocation pointer for each of NUM_AGENTS agents, all as register arrays. It serves single-cycle-latency address grants to agents, with wrap-around inside each partition. It is programmed over the local bus (LB) and self-initialises to an even split of memory on reset or on command.

Parameters:
MEM_ADDR_W, 27, memory address width
NUM_AGENTS, 4, number of agents/partitions (>=2)
LB_DATA_W, 32, LB data width (>= MEM_ADDR_W)
LB_ADDR_W, 8, LB address width
LEN_W, 8, agent burst length width
DEFAULT_DATA_VAL, 'hdeadbabe, read data for unmapped LB addresses
AGENT_ID_W, $clog2(NUM_AGENTS), derived; do not override
PART_SIZE, 2**MEM_ADDR_W/NUM_AGENTS, default partition size in words

Ports:
clk  in  1  clock; one clock domain
rst  in  1  reset, synchronous, active-high
lb_wr_en  in  1  LB write strobe
lb_rd_en  in  1  LB read strobe
lb_addr  in  LB_ADDR_W  LB register address
lb_wr_data  in  LB_DATA_W  LB write data
lb_wr_valid  out  1  write ack, 1 cycle after lb_wr_en
lb_rd_valid  out  1  read valid, 1 cycle after lb_rd_en
lb_rd_data  out  LB_DATA_W  read data
agent_req  in  1  allocation request
agent_id  in  AGENT_ID_W  requesting agent
agent_len  in  LEN_W  burst length in words
agent_gnt  out  1  grant pulse
agent_addr  out  MEM_ADDR_W  granted base address
agent_err  out  1  pulse with agent_gnt=0: request rejected
busy  out  1  init sweep in progress

Behaviour:
- Reset (clk edge with rst=1): all outputs 0; mode=0; hst_addr=0; status=0. FSM enters INIT.
- LB map: 0x00 CNTRL (bit0 mode: 0 normal, 1 config; bit1 init, write-1 self-clearing, reads 0); 0x01 STATUS (bit0 busy, bit1 cfg_err sticky, bit2 len_err sticky; write-1-to-clear); 0x02 NUM_AGENTS (RO); 0x03 ADDR (hst_addr); 0x04 START_DATA; 0x05 END_DATA; 0x06 PTR_DATA (RO, ptr[hst_addr]). Any other address reads DEFAULT_DATA_VAL.
- Read data is zero-extended. lb_wr_valid and lb_rd_valid are registered copies of the strobes, so latency is 1. Reads reflect state as of the strobe cycle.
- hst_addr write uses lb_wr_data[AGENT_ID_W-1:0]. A value >= NUM_AGENTS sets cfg_err and is ignored.
- START_DATA write: allowed only when mode=1 and not busy. It sets start[hst_addr] and ptr[hst_addr] to lb_wr_data[MEM_ADDR_W-1:0].
- END_DATA write: allowed only when mode=1 and not busy. If the value is < start[hst_addr], cfg_err is set and the write is dropped; otherwise end[hst_addr] is written.
- Disallowed START/END writes are dropped and set cfg_err. lb_wr_valid still pulses.
- FSM states: IDLE, INIT.
  - INIT: counter i from 0 to NUM_AGENTS-1, one agent per cycle. Writes start=i*PART_SIZE, end=start+PART_SIZE-1, ptr=start. After the last agent, go to IDLE.
  - busy=1 throughout INIT. INIT lasts NUM_AGENTS cycles.
  - IDLE -> INIT on a CNTRL write with bit1=1.
  - An init write during INIT restarts the counter at 0.
  - rst during INIT restarts INIT from 0.
- Grant rules. Requests are evaluated in the req cycle; outputs are registered, giving 1-cycle latency. agent_gnt/agent_err are single-cycle pulses.
  - If mode=1, busy=1, agent_id >= NUM_AGENTS, agent_len=0, or agent_len > end-start+1: agent_err=1, agent_gnt=0, no state change. The agent_len cases also set len_err.
  - Otherwise, let L=agent_len and p=ptr[id]:
    - if p+L-1 <= end: base=p;
    - else base=start (wrap).
  - agent_gnt=1, agent_addr=base.
  - ptr[id] <= base+L; if base+L > end, ptr[id] <= start.
  - Pointer arithmetic uses MEM_ADDR_W+1 bits, so there is no overflow at the top of memory.
- Back-to-back requests, including same agent on consecutive cycles, must see the updated pointer. Throughput is 1 grant per cycle.
- A CNTRL mode write and agent_req in the same cycle: the request is judged on the pre-write mode.
- agent_addr holds its last value when no grant is issued.

Test Plan:
- Reset then wait -> busy=1 for 4 cycles, then 0. Reading START/END for agent 2 gives 0x4000000/0x5FFFFFF.
- Normal mode, agent 1 requests len 16 three times back-to-back -> grants 0x2000000, 0x2000010, 0x2000020 on consecutive cycles.
- Config: mode=1, ADDR=0, START=0x100, END=0x11F, mode=0. Agent 0 requests len 16,16,16 -> addrs 0x100, 0x110, 0x100 (wrap); PTR_DATA then reads 0x110.
- Config END=0x0FF with START=0x100 -> cfg_err=1 and END unchanged. START write with mode=0 -> cfg_err=1, dropped.
- agent_len=0, agent_len larger than the partition, and a request while mode=1 -> agent_err pulses with no gnt. len_err is set for the first two only.
- CNTRL init write mid-traffic -> requests during the 4 busy cycles get agent_err. Afterwards, pointers are back at default starts. Unmapped address 0x20 reads 0xdeadbabe.
